// File: rtl/decode_ctrl_seq.sv
// rtl/decode_ctrl_seq.sv - registered instruction decoder with multi-cycle issue hold for MULT and FR add/sub.
// Optional DOUBLE_FMT_EN: makes FR fmt 0x11 legal with latency 2*FP_LATENCY.
module decode_ctrl_seq #(
  parameter int FP_LATENCY   = 3,
  parameter int MULT_LATENCY = 2,
  parameter int CNT_W        = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] functcode,
  input  logic [4:0] fmt,
  input  logic       zero,
  output logic       ctrl_valid,
  output logic       stall,
  output logic       illegal,
  output logic       regWrite,
  output logic       muxA_en,
  output logic       dm_we,
  output logic       multiplyEn,
  output logic [1:0] muxB_en,
  output logic [1:0] regWriteAddSelect,
  output logic [1:0] muxPC,
  output logic [1:0] muxWD3_en,
  output logic [2:0] ALUop,
  output logic       floatWriteAddrSelect,
  output logic       floatRegWrite,
  output logic       floatRWSelect
);

  typedef struct packed {
    logic       reg_write;
    logic       mux_a_en;
    logic       dm_we;
    logic       multiply_en;
    logic [1:0] mux_b_en;
    logic [1:0] reg_write_add_select;
    logic [1:0] mux_pc;
    logic [1:0] mux_wd3_en;
    logic [2:0] alu_op;
    logic       float_write_addr_select;
    logic       float_reg_write;
    logic       float_rw_select;
  } ctrl_t;

  typedef enum logic {S_ISSUE, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  ctrl_t            bundle, bundle_nxt, dec;
  logic             valid_q, valid_nxt, illegal_q, illegal_nxt;
  logic             dec_illegal;
  logic [CNT_W-1:0] dec_lat;

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    dec_lat     = CNT_W'(1);
    case (opcode)
      6'h00: begin
        dec.mux_b_en             = 2'd1;
        dec.reg_write_add_select = 2'd2;
        dec.mux_wd3_en           = 2'd1;
        case (functcode)
          6'h20: dec.reg_write = 1'b1;
          6'h22: begin dec.reg_write = 1'b1; dec.alu_op = 3'd1; end
          6'h2A: begin dec.reg_write = 1'b1; dec.alu_op = 3'd3; end
          6'h08: dec.mux_pc = 2'd2;
          6'h18: begin dec.multiply_en = 1'b1; dec_lat = CNT_W'(MULT_LATENCY); end
          6'h10: begin dec.reg_write = 1'b1; dec.mux_wd3_en = 2'd2; end
          6'h12: begin dec.reg_write = 1'b1; dec.mux_wd3_en = 2'd3; end
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h23: dec.reg_write = 1'b1;
      6'h2B, 6'h39: dec.dm_we = 1'b1;
      6'h31: begin dec.float_write_addr_select = 1'b1; dec.float_reg_write = 1'b1; end
      6'h04: begin dec.mux_b_en = 2'd1; dec.alu_op = 3'd1; dec.mux_pc = zero ? 2'd3 : 2'd0; end
      6'h05: begin dec.mux_b_en = 2'd1; dec.alu_op = 3'd1; dec.mux_pc = zero ? 2'd0 : 2'd3; end
      6'h08: begin dec.reg_write = 1'b1; dec.mux_wd3_en = 2'd1; end
      6'h0E: begin dec.reg_write = 1'b1; dec.mux_wd3_en = 2'd1; dec.alu_op = 3'd2; end
      6'h02: dec.mux_pc = 2'd1;
      6'h03: begin
        dec.reg_write = 1'b1; dec.mux_a_en = 1'b1; dec.mux_b_en = 2'd2;
        dec.reg_write_add_select = 2'd1; dec.mux_wd3_en = 2'd1; dec.mux_pc = 2'd1;
      end
      6'h11: begin
        dec.float_reg_write      = 1'b1;
        dec.float_rw_select      = 1'b1;
        dec.reg_write_add_select = 2'd3;
        dec.alu_op               = {2'b00, functcode[0]};
        dec_lat                  = CNT_W'(FP_LATENCY);
        if (functcode != 6'h00 && functcode != 6'h01) dec_illegal = 1'b1;
`ifdef DOUBLE_FMT_EN
        else if (fmt == 5'h11) dec_lat = CNT_W'(2 * FP_LATENCY);
`endif
        else if (fmt != 5'h10) dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // An undecodable instruction must not leak partial controls.
    if (dec_illegal) begin
      dec     = '0;
      dec_lat = CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bundle_nxt  = bundle;
    valid_nxt   = 1'b0;
    illegal_nxt = 1'b0;
    case (state)
      S_ISSUE: begin
        if (instr_valid) begin
          bundle_nxt = dec;
          if (dec_lat <= CNT_W'(1)) begin
            valid_nxt   = 1'b1;
            illegal_nxt = dec_illegal;
          end else begin
            cnt_nxt   = dec_lat - CNT_W'(1);
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_nxt   = '0;
          valid_nxt = 1'b1;
          state_nxt = S_ISSUE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_ISSUE;
      cnt       <= '0;
      bundle    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bundle    <= bundle_nxt;
      valid_q   <= valid_nxt;
      illegal_q <= illegal_nxt;
    end
  end

  assign instr_ready = (state == S_ISSUE);
  assign stall       = (state == S_WAIT);
  assign ctrl_valid  = valid_q;
  assign illegal     = illegal_q;

  // Side-effecting enables stay off until the long-latency result is due.
  assign regWrite             = bundle.reg_write & ~stall;
  assign dm_we                = bundle.dm_we & ~stall;
  assign multiplyEn           = bundle.multiply_en & ~stall;
  assign floatRegWrite        = bundle.float_reg_write & ~stall;
  assign muxA_en              = bundle.mux_a_en;
  assign muxB_en              = bundle.mux_b_en;
  assign regWriteAddSelect    = bundle.reg_write_add_select;
  assign muxPC                = bundle.mux_pc;
  assign muxWD3_en            = bundle.mux_wd3_en;
  assign ALUop                = bundle.alu_op;
  assign floatWriteAddrSelect = bundle.float_write_addr_select;
  assign floatRWSelect        = bundle.float_rw_select;

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// tb/tb_decode_ctrl_seq.sv - randomized bench for decode_ctrl_seq against a mnemonic-level reference model.
module tb_decode_ctrl_seq;

  localparam int FP  = 3;
  localparam int MUL = 2;

  localparam int K_ADD = 0, K_SUB = 1, K_SLT = 2, K_JR = 3, K_MULT = 4, K_MFHI = 5, K_MFLO = 6;
  localparam int K_LW = 7, K_SW = 8, K_SWC1 = 9, K_BEQ = 10, K_BNE = 11, K_ADDI = 12, K_XORI = 13;
  localparam int K_J = 14, K_JAL = 15, K_ADDS = 16, K_SUBS = 17, K_LWC1 = 18, K_ADDD = 19;
  localparam int K_BADOP = 20, K_BADR = 21, K_BADFR = 22, K_NUM = 23;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] functcode = '0;
  logic [4:0] fmt = '0;
  logic       zero = 1'b0;
  logic       instr_ready, ctrl_valid, stall, illegal;
  logic       regWrite, muxA_en, dm_we, multiplyEn;
  logic [1:0] muxB_en, regWriteAddSelect, muxPC, muxWD3_en;
  logic [2:0] ALUop;
  logic       floatWriteAddrSelect, floatRegWrite, floatRWSelect;

  decode_ctrl_seq #(.FP_LATENCY(FP), .MULT_LATENCY(MUL), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .functcode(functcode), .fmt(fmt), .zero(zero),
    .ctrl_valid(ctrl_valid), .stall(stall), .illegal(illegal),
    .regWrite(regWrite), .muxA_en(muxA_en), .dm_we(dm_we), .multiplyEn(multiplyEn),
    .muxB_en(muxB_en), .regWriteAddSelect(regWriteAddSelect), .muxPC(muxPC), .muxWD3_en(muxWD3_en),
    .ALUop(ALUop), .floatWriteAddrSelect(floatWriteAddrSelect),
    .floatRegWrite(floatRegWrite), .floatRWSelect(floatRWSelect)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk(input logic rw, input logic ma, input logic we, input logic me,
                                     input logic [1:0] mb, input logic [1:0] ras, input logic [1:0] pc,
                                     input logic [1:0] wd3, input logic [2:0] alu, input logic fwas,
                                     input logic frw, input logic frs);
    return {rw, ma, we, me, mb, ras, pc, wd3, alu, fwas, frw, frs};
  endfunction

  function automatic logic [17:0] dut_ctrl();
    return {regWrite, muxA_en, dm_we, multiplyEn, muxB_en, regWriteAddSelect, muxPC, muxWD3_en,
            ALUop, floatWriteAddrSelect, floatRegWrite, floatRWSelect};
  endfunction

  // Expected control bundle, latency and legality for each mnemonic.
  task automatic ref_decode(input int k, input logic z, output logic [17:0] v, output int lat, output bit ill);
    v = '0; lat = 1; ill = 1'b0;
    case (k)
      K_ADD:  v = mk(1,0,0,0,1,2,0,1,0,0,0,0);
      K_SUB:  v = mk(1,0,0,0,1,2,0,1,1,0,0,0);
      K_SLT:  v = mk(1,0,0,0,1,2,0,1,3,0,0,0);
      K_JR:   v = mk(0,0,0,0,1,2,2,1,0,0,0,0);
      K_MULT: begin v = mk(0,0,0,1,1,2,0,1,0,0,0,0); lat = MUL; end
      K_MFHI: v = mk(1,0,0,0,1,2,0,2,0,0,0,0);
      K_MFLO: v = mk(1,0,0,0,1,2,0,3,0,0,0,0);
      K_LW:   v = mk(1,0,0,0,0,0,0,0,0,0,0,0);
      K_SW, K_SWC1: v = mk(0,0,1,0,0,0,0,0,0,0,0,0);
      K_BEQ:  v = mk(0,0,0,0,1,0,z ? 2'd3 : 2'd0,0,1,0,0,0);
      K_BNE:  v = mk(0,0,0,0,1,0,z ? 2'd0 : 2'd3,0,1,0,0,0);
      K_ADDI: v = mk(1,0,0,0,0,0,0,1,0,0,0,0);
      K_XORI: v = mk(1,0,0,0,0,0,0,1,2,0,0,0);
      K_J:    v = mk(0,0,0,0,0,0,1,0,0,0,0,0);
      K_JAL:  v = mk(1,1,0,0,2,1,1,1,0,0,0,0);
      K_ADDS: begin v = mk(0,0,0,0,0,3,0,0,0,0,1,1); lat = FP; end
      K_SUBS: begin v = mk(0,0,0,0,0,3,0,0,1,0,1,1); lat = FP; end
      K_LWC1: v = mk(0,0,0,0,0,0,0,0,0,1,1,0);
`ifdef DOUBLE_FMT_EN
      K_ADDD: begin v = mk(0,0,0,0,0,3,0,0,0,0,1,1); lat = 2 * FP; end
`endif
      default: ill = 1'b1;
    endcase
  endtask

  task automatic set_instr(input int k);
    fmt = 5'h00; functcode = 6'h00;
    case (k)
      K_ADD:  functcode = 6'h20;
      K_SUB:  functcode = 6'h22;
      K_SLT:  functcode = 6'h2A;
      K_JR:   functcode = 6'h08;
      K_MULT: functcode = 6'h18;
      K_MFHI: functcode = 6'h10;
      K_MFLO: functcode = 6'h12;
      K_BADR: functcode = 6'h3F;
      default: ;
    endcase
    case (k)
      K_LW: opcode = 6'h23;   K_SW: opcode = 6'h2B;   K_SWC1: opcode = 6'h39;
      K_BEQ: opcode = 6'h04;  K_BNE: opcode = 6'h05;  K_ADDI: opcode = 6'h08;
      K_XORI: opcode = 6'h0E; K_J: opcode = 6'h02;    K_JAL: opcode = 6'h03;
      K_LWC1: opcode = 6'h31; K_BADOP: opcode = 6'h3F;
      K_ADDS:  begin opcode = 6'h11; fmt = 5'h10; functcode = 6'h00; end
      K_SUBS:  begin opcode = 6'h11; fmt = 5'h10; functcode = 6'h01; end
      K_ADDD:  begin opcode = 6'h11; fmt = 5'h11; functcode = 6'h00; end
      K_BADFR: begin opcode = 6'h11; fmt = 5'h10; functcode = 6'h02; end
      default: opcode = 6'h00;
    endcase
  endtask

  int          m_wait = 0;
  bit          m_valid = 1'b0, m_ill = 1'b0;
  logic [17:0] m_exp = '0, m_pend = '0;
  int          cur_k = K_ADD;

  // One clock: present inputs, let the model follow the edge, check at the falling edge.
  task automatic step(input bit v, input int k, input logic z);
    logic [17:0] dv; int lat; bit ill;
    instr_valid = v; zero = z; cur_k = k; set_instr(k);
    @(posedge clk);
    m_valid = 1'b0; m_ill = 1'b0;
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin m_valid = 1'b1; m_exp = m_pend; end
    end else if (v) begin
      ref_decode(k, z, dv, lat, ill);
      if (lat <= 1) begin m_valid = 1'b1; m_exp = dv; m_ill = ill; end
      else begin m_wait = lat - 1; m_pend = dv; end
    end
    @(negedge clk);
    check("ready", instr_ready, m_wait == 0);
    check("stall", stall, m_wait > 0);
    check("ctrl_valid", ctrl_valid, m_valid);
    check("illegal", illegal, m_ill);
    if (m_valid) check("bundle", dut_ctrl(), m_exp);
    if (m_wait > 0) check("wait_we_off", {regWrite, dm_we, multiplyEn, floatRegWrite}, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, cur_k, 1'b0);
  endtask

  task automatic run_until_ready(input int k, input logic z);
    step(1'b1, k, z);
    for (int i = 0; i < 40 && m_wait > 0; i++) step(1'b1, k, z);
    check("ready_timeout", m_wait == 0, 1);
  endtask

  initial begin
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_outs", {ctrl_valid, stall, illegal, dut_ctrl()}, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    step(1'b1, K_ADD, 1'b0);
    check("add_regwrite", regWrite, 1);
    check("add_ras", regWriteAddSelect, 2);
    step(1'b1, K_BEQ, 1'b1);
    check("beq_pc", muxPC, 3);
    step(1'b1, K_BNE, 1'b1);
    check("bne_pc", muxPC, 0);
    idle(1);

    step(1'b1, K_ADDS, 1'b0);
    check("fr_frw_wait", floatRegWrite, 0);
    step(1'b1, K_ADDS, 1'b0);
    check("fr_stall2", stall, 1);
    step(1'b0, K_ADDS, 1'b0);
    check("fr_done", {ctrl_valid, floatRegWrite, floatRWSelect}, 3'b111);

    step(1'b1, K_MULT, 1'b0);
    step(1'b1, K_MFLO, 1'b0);
    check("mult_valid", ctrl_valid, 1);
    step(1'b1, K_MFLO, 1'b0);
    check("mflo_wd3", {regWrite, muxWD3_en}, 3'b111);

    step(1'b1, K_BADOP, 1'b0);
    check("badop", {illegal, ctrl_valid, dut_ctrl()}, {2'b11, 18'h0});
    step(1'b1, K_BADR, 1'b0);
    step(1'b1, K_BADFR, 1'b0);
    run_until_ready(K_ADDD, 1'b0);
    idle(2);

    step(1'b1, K_SUBS, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_outs", {ctrl_valid, stall, illegal, dut_ctrl()}, 0);
    check("async_rst_ready", instr_ready, 1);
    instr_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    m_wait = 0; m_valid = 1'b0; m_ill = 1'b0;
    idle(FP + 2);

    for (int i = 0; i < 600; i++) begin
      int k; bit v;
      if (m_wait > 0) begin k = cur_k; v = 1'b1; end
      else begin k = $urandom_range(0, K_NUM - 1); v = ($urandom_range(0, 3) != 0); end
      step(v, k, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_seq.md
# decode_ctrl_seq

Registered, multi-cycle successor to the combinational instruction decoder. Accepts one instruction per handshake, decodes it into the datapath control bundle, and holds issue for a parameterised number of cycles on long-latency operations: MULT and the FPU arithmetic core (FR add.s/sub.s). Sits between instruction fetch and the integer/float datapaths. Provides the stall and valid qualification that the single-cycle decoder lacks.

## Interface
- FP_LATENCY, 3: cycles from accept to completion for single-precision FR add.s/sub.s; legal range 1..15.
- MULT_LATENCY, 2: cycles from accept to completion for MULT; legal range 1..15.
- CNT_W, 5: width of the internal wait counter; must hold 2*FP_LATENCY.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  opcode/functcode/fmt/zero are valid this cycle.
- instr_ready  out  1  decoder can accept; 1 only in ISSUE.
- opcode  in  6  instruction [31:26].
- functcode  in  6  instruction [5:0].
- fmt  in  5  FR format field (0x10 single, 0x11 double).
- zero  in  1  ALU zero flag; sampled at accept.
- ctrl_valid  out  1  one-cycle pulse; control bundle applies this cycle.
- stall  out  1  high while in WAIT.
- illegal  out  1  one-cycle pulse with ctrl_valid for an undecodable instruction.
- regWrite, muxA_en, dm_we, multiplyEn  out  1 each  integer controls.
- muxB_en, regWriteAddSelect, muxPC, muxWD3_en  out  2 each.
- ALUop  out  3  0 ADD, 1 SUB, 2 XOR, 3 SLT.
- floatWriteAddrSelect, floatRegWrite, floatRWSelect  out  1 each.

## Operation
- States:
  - ISSUE: ready. Accept happens when instr_valid && instr_ready.
  - WAIT: counting down.
- Reset: state ISSUE, counter 0, instr_ready 1. Every other output is 0, including all controls, ctrl_valid, stall and illegal.
- Single-cycle instructions: on accept, register the decoded bundle, pulse ctrl_valid, and stay in ISSUE.
- Multi-cycle instructions:
  - Applies to MULT (R-type funct 0x18) and FR with funct 0x0 or 0x1.
  - Latency L is MULT_LATENCY or FP_LATENCY.
  - If L == 1: handled as single-cycle.
  - Otherwise: latch the bundle, load counter with L-1, enter WAIT, and assert stall.
  - Write enables (regWrite, floatRegWrite, dm_we) and multiplyEn are held 0 during WAIT.
  - When the counter reaches 0: drive the full bundle, pulse ctrl_valid, return to ISSUE.
- Decode table. Unlisted fields are 0.
  - ADD/SUB/SLT: regWrite=1, muxB_en=1, regWriteAddSelect=2, muxWD3_en=1, ALUop 0/1/3.
  - JR: muxPC=2, muxB_en=1, regWriteAddSelect=2, muxWD3_en=1.
  - MULT: multiplyEn=1, muxB_en=1, regWriteAddSelect=2, muxWD3_en=1.
  - MFHI/MFLO: regWrite=1, muxB_en=1, regWriteAddSelect=2, muxWD3_en=2/3.
  - LW: regWrite=1.
  - SW and SWC1: dm_we=1.
  - BEQ/BNE: muxB_en=1, ALUop=1, muxPC=3 when the sampled zero is 1/0 respectively, else 0.
  - ADDI: regWrite=1, muxWD3_en=1.
  - XORI: regWrite=1, muxWD3_en=1, ALUop=2.
  - J: muxPC=1.
  - JAL: regWrite=1, muxA_en=1, muxB_en=2, regWriteAddSelect=1, muxWD3_en=1, muxPC=1.
  - FR: floatRegWrite=1, floatRWSelect=1, regWriteAddSelect=3, muxPC=0, ALUop from funct.
  - LWC1: floatWriteAddrSelect=1, floatRegWrite=1, muxPC=0.
- Illegal: any other opcode, R-type funct, or FR funct/fmt. Response: all controls 0, ctrl_valid=1, illegal=1, 1 cycle, stay in ISSUE.
- Between pulses, controls hold their last value but are qualified only by ctrl_valid.

## Timing
- Single-cycle: accept at edge N, then ctrl_valid high for one cycle following edge N.
- Multi-cycle: accept at edge N.
  - stall and !instr_ready during cycles following edges N..N+L-2.
  - ctrl_valid in the cycle following edge N+L-1.
  - ready again in that same cycle, so back-to-back accept is allowed.
- instr_valid while !instr_ready is ignored. The source must hold its inputs.
- zero is sampled only at the accept edge. Later changes to zero do not affect the branch decision.
- reset_n asserted mid-WAIT: immediately return to reset values. The pending result is discarded and no ctrl_valid is issued.

## Configuration
- DOUBLE_FMT_EN:
  - Defined: FR with fmt=0x11 is legal and uses latency 2*FP_LATENCY.
  - Undefined: fmt=0x11 decodes as illegal.
- fmt=0x10 is always legal.

## Test plan
- Reset, then ADD (op 0, funct 0x20) -> ctrl_valid 1 cycle after accept, regWrite=1, ALUop=0, regWriteAddSelect=2, stall=0.
- BEQ with zero=1, then BNE with zero=1 -> muxPC=3 then muxPC=0; ALUop=1 both.
- FR add.s (op 0x11, fmt 0x10, funct 0), FP_LATENCY=3 -> stall for 2 cycles, instr_ready=0, floatRegWrite=0 during WAIT; ctrl_valid on the 3rd cycle with floatRegWrite=1, floatRWSelect=1.
- MULT, MULT_LATENCY=2, then MFLO presented immediately -> MFLO accepted on the cycle MULT's ctrl_valid pulses; next cycle muxWD3_en=3, regWrite=1.
- Opcode 0x3F -> illegal=1 and ctrl_valid=1 together; all enables 0.
- reset_n low during FR WAIT -> all outputs 0 asynchronously; no ctrl_valid after release. With DOUBLE_FMT_EN, fmt 0x11 -> ctrl_valid after 6 cycles; without it, fmt 0x11 -> illegal.
